// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: bubble encoding, reset PC and the IF/ID bundle
// that decode imports.
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry capture register that keeps the F2 word alive while the PC is frozen.
// The first capture after a clear wins; later captures are ignored until cleared.
module fetch_hold_buf (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] din,
    output logic        valid,
    output logic [31:0] data
);

    // Clear dominates capture; a held word is never overwritten.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture && !valid) begin
            valid <= 1'b1;
            data  <= din;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, sync IMEM interface with an F2 tracking
// stage, and the IF/ID pipeline register. Priority on every edge is
// redirect > stall > advance.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN      = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(fetch_pkg::RESET_PC),
    parameter logic [31:0]     NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_rd_en,
    input  logic [31:0]     imem_data,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    output logic [31:0]     if_instr,
    output logic            if_valid
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] f2_pc_q;
    logic            f2_valid_q;
    logic            hold_valid;
    logic [31:0]     hold_data;
    logic [31:0]     f2_instr;
    logic            advance;

    assign advance    = !redirect && !stall;
    assign imem_addr  = pc_q;
    assign imem_rd_en = RST_N;
    // Once the PC freezes, imem_data moves on to pc_q, so the captured word is used.
    assign f2_instr   = hold_valid ? hold_data : imem_data;

    fetch_hold_buf u_hold (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .capture (stall),
        .clear   (!stall || redirect),
        .din     (imem_data),
        .valid   (hold_valid),
        .data    (hold_data)
    );

    // PC register: reload on redirect, freeze on stall, otherwise step by 4 (wraps).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_pc;
        end else if (!stall) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

    // F2 tracks which address the IMEM is returning data for this cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            f2_pc_q    <= '0;
            f2_valid_q <= 1'b0;
        end else if (redirect) begin
            f2_valid_q <= 1'b0;
        end else if (advance) begin
            f2_pc_q    <= pc_q;
            f2_valid_q <= 1'b1;
        end
    end

    // IF/ID register: bubble on redirect (PC fields hold), load F2 on advance.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            if_pc    <= '0;
            if_pc4   <= '0;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (redirect) begin
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (advance) begin
            if_pc    <= f2_pc_q;
            if_pc4   <= f2_pc_q + XLEN'(4);
            if_instr <= f2_instr;
            if_valid <= f2_valid_q;
        end
    end

endmodule
